// File: rtl/pwm_output_stage.sv
// Purpose : 16-pin output stage; each pin is static low, static high, or follows one shared 8-bit PWM waveform.
// Latency : enable changes reach out 1 clk later; duty changes apply from the next period boundary, visible 1 clk after it.
// Backpressure: none; the PWM period is free-running and every input is sampled every clk.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   en_reg_out_15_8/7_0  per-pin output enable (0 forces the pin low)
//   en_reg_pwm_15_8/7_0  per-pin PWM mode (1 = follow PWM, 0 = static high), only meaningful when enabled
//   pwm_duty_cycle       requested duty, 0x00 = always low, 0xFF = always high
//   out                  registered pin drive, out[15:8] from the *_15_8 registers
//   period_start         one-clk pulse on the first cycle of each PWM period, aligned with out
module pwm_output_stage #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    // The prescaler is 16 bits wide, so the divide ratio must fit in it.
    if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_clk_div_range
        $error("pwm_output_stage: CLK_DIV must be in 1..65535");
    end

    localparam logic [15:0] PRESCALE_MAX = 16'(CLK_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] prescale_cnt_q, prescale_cnt_d;
    logic [7:0]  pwm_cnt_q,      pwm_cnt_d;
    logic [7:0]  duty_shadow_q,  duty_shadow_d;
    logic [15:0] out_q,          out_d;
    logic        period_start_q, period_start_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        tick;
    logic        load;
    logic [7:0]  eff_duty;
    logic        pwm_sig;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    // Prescaler: one PWM counter step every CLK_DIV clks. With CLK_DIV = 1
    // the count never leaves 0 and tick is permanently high.
    always_comb begin
        tick           = (prescale_cnt_q == PRESCALE_MAX);
        prescale_cnt_d = tick ? 16'h0000 : (prescale_cnt_q + 16'd1);
    end

    // PWM counter wraps 255 -> 0 naturally through 8-bit overflow.
    always_comb begin
        pwm_cnt_d = tick ? (pwm_cnt_q + 8'd1) : pwm_cnt_q;
    end

    // Period boundary. Both counters restart from 0 together after reset,
    // so the very first cycle out of reset is also a boundary.
    always_comb begin
        load = (prescale_cnt_q == 16'h0000) && (pwm_cnt_q == 8'h00);
    end

    // Duty is only sampled at the period boundary so a write arriving
    // mid-period cannot chop or stretch the pulse in flight. On the load
    // cycle itself the live value is used, so a new duty governs the whole
    // new period including its first step.
    always_comb begin
        duty_shadow_d = load ? pwm_duty_cycle : duty_shadow_q;
        eff_duty      = load ? pwm_duty_cycle : duty_shadow_q;
    end

    // 0xFF is treated as full-on; a plain compare would leave one low step
    // per period when pwm_cnt reaches 255.
    always_comb begin
        pwm_sig = (eff_duty == 8'hFF) ? 1'b1 : (pwm_cnt_q < eff_duty);
    end

    // Per-pin mux: disabled -> 0, enabled static -> 1, enabled PWM -> pwm_sig.
    // Enables are deliberately not shadowed so overrides act on the next clk.
    always_comb begin
        en_out         = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm         = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        out_d          = en_out & (~en_pwm | {16{pwm_sig}});
        period_start_d = load;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_cnt_q <= 16'h0000;
            pwm_cnt_q      <= 8'h00;
            duty_shadow_q  <= 8'h00;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            prescale_cnt_q <= prescale_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Purpose : directed bench for pwm_output_stage, one instance at CLK_DIV=13 and one at CLK_DIV=1.
// Latency : checks out/period_start one clk after each stimulus change, sampling on the falling edge.
// Backpressure: not applicable; stimulus is driven on falling edges.
module tb_pwm_output_stage;

    logic        clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out13;
    logic        ps13;
    logic [15:0] out1;
    logic        ps1;

    int n_cmp  = 0;
    int n_fail = 0;

    pwm_output_stage #(.CLK_DIV(13)) u_dut13 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out13),
        .period_start    (ps13)
    );

    pwm_output_stage #(.CLK_DIV(1)) u_dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out1),
        .period_start    (ps1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [15:0] exp_hi;   // expected out while pwm_sig = 1
        logic [15:0] exp_lo;   // expected out while pwm_sig = 0
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        en_reg_out_15_8 = eo[15:8];
        en_reg_out_7_0  = eo[7:0];
        en_reg_pwm_15_8 = ep[15:8];
        en_reg_pwm_7_0  = ep[7:0];
    endtask

    // Leaves the bench on a falling edge with reset just released; the next
    // rising edge is the first (load) cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Observes n cycles of one instance (sel=1 -> CLK_DIV=1 instance).
    // hi    : cycles with out == va
    // other : cycles with out neither va nor vb
    // ps_*  : period_start pulse count and first/last index within the window
    task automatic measure(input bit sel, input int n, input logic [15:0] va, input logic [15:0] vb,
                           output int hi, output int other, output int ps_n,
                           output int ps_first, output int ps_last);
        logic [15:0] o;
        logic        p;
        hi = 0; other = 0; ps_n = 0; ps_first = -1; ps_last = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = sel ? out1 : out13;
            p = sel ? ps1 : ps13;
            if (o == va) hi++;
            else if (o != vb) other++;
            if (p) begin
                ps_n++;
                if (ps_first < 0) ps_first = i;
                ps_last = i;
            end
        end
    endtask

    initial begin
        int hi, other, ps_n, ps_first, ps_last;

        vecs[0] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[1] = '{16'h00FF, 16'h0000, 16'h00FF, 16'h00FF};
        vecs[2] = '{16'hFFFF, 16'hFF00, 16'hFFFF, 16'h00FF};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[4] = '{16'hA5C3, 16'h0F0F, 16'hA5C3, 16'hA0C0};
        vecs[5] = '{16'h1234, 16'hFFFF, 16'h1234, 16'h0000};
        vecs[6] = '{16'hF0F0, 16'h3C3C, 16'hF0F0, 16'hC0C0};
        vecs[7] = '{16'h8001, 16'h0001, 16'h8001, 16'h8000};

        rst_n = 1'b0;
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h80;
        #1;
        check("reset_out13", 32'(out13), 32'h0000);
        check("reset_ps13", 32'(ps13), 32'h0);
        check("reset_out1", 32'(out1), 32'h0000);

        // ---- Table-driven enable/mode vectors, duty 0x80 (CLK_DIV=13) ----
        do_reset();
        @(negedge clk);                                   // edge 1: load
        check("first_ps13", 32'(ps13), 32'h1);
        check("first_ps1", 32'(ps1), 32'h1);
        check("first_out13", 32'(out13), 32'hFFFF);
        @(negedge clk);                                   // edge 2
        check("second_ps13", 32'(ps13), 32'h0);
        // edges 3..10: pwm_cnt 0, high phase
        for (int i = 0; i < 8; i++) begin
            set_en(vecs[i].en_out, vecs[i].en_pwm);
            @(negedge clk);
            check($sformatf("tbl_hi[%0d]", i), 32'(out13), 32'(vecs[i].exp_hi));
        end
        repeat (1690) @(negedge clk);                     // edge 1700: pwm_cnt 130, low phase
        for (int i = 0; i < 8; i++) begin
            set_en(vecs[i].en_out, vecs[i].en_pwm);
            @(negedge clk);
            check($sformatf("tbl_lo[%0d]", i), 32'(out13), 32'(vecs[i].exp_lo));
        end

        // ---- Asynchronous reset mid-period, high phase of next period ----
        set_en(16'hFFFF, 16'hFFFF);
        repeat (1720) @(negedge clk);                     // edge 3428: pwm_cnt 7
        check("pre_reset_out13", 32'(out13), 32'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out13", 32'(out13), 32'h0000);
        check("async_reset_ps13", 32'(ps13), 32'h0);
        check("async_reset_out1", 32'(out1), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Duty 0x80 over three periods ----
        measure(0, 3 * 3328, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("d80_high", 32'(hi), 32'd4992);
        check("d80_other", 32'(other), 32'd0);
        check("d80_ps_n", 32'(ps_n), 32'd3);
        check("d80_ps_first", 32'(ps_first), 32'd0);
        check("d80_ps_span", 32'(ps_last - ps_first), 32'd6656);

        // ---- Duty 0x01 ----
        pwm_duty_cycle = 8'h01;
        do_reset();
        measure(0, 3328, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("d01_high", 32'(hi), 32'd13);
        check("d01_other", 32'(other), 32'd0);
        check("d01_ps_n", 32'(ps_n), 32'd1);

        // ---- Duty 0xFF: never low ----
        pwm_duty_cycle = 8'hFF;
        do_reset();
        measure(0, 3 * 3328, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("dff_high", 32'(hi), 32'd9984);
        check("dff_ps_n", 32'(ps_n), 32'd3);

        // ---- Static modes, duty 0x00 ----
        set_en(16'hFFFF, 16'hFF00);
        pwm_duty_cycle = 8'h00;
        do_reset();
        measure(0, 3328, 16'h00FF, 16'h00FF, hi, other, ps_n, ps_first, ps_last);
        check("static13_const", 32'(hi), 32'd3328);
        measure(1, 256, 16'h00FF, 16'h00FF, hi, other, ps_n, ps_first, ps_last);
        check("static1_const", 32'(hi), 32'd256);

        // ---- Glitch-free update: 0x40 -> 0xC0 at pwm_cnt 0x80 ----
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h40;
        do_reset();
        measure(0, 1664, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("g1_high", 32'(hi), 32'd832);
        check("g1_ps_n", 32'(ps_n), 32'd1);
        pwm_duty_cycle = 8'hC0;
        measure(0, 1664, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("g2_high", 32'(hi), 32'd0);
        check("g2_ps_n", 32'(ps_n), 32'd0);
        measure(0, 3328, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("g3_high", 32'(hi), 32'd2496);
        check("g3_ps_first", 32'(ps_first), 32'd0);
        check("g3_other", 32'(other), 32'd0);

        // ---- Boundary load on CLK_DIV=1: duty written in the load cycle ----
        pwm_duty_cycle = 8'h10;
        do_reset();
        measure(1, 256, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("b1_high", 32'(hi), 32'd16);
        check("b1_ps_first", 32'(ps_first), 32'd0);
        pwm_duty_cycle = 8'h03;                           // next rising edge is load
        measure(1, 100, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("b2_high", 32'(hi), 32'd3);
        check("b2_ps_first", 32'(ps_first), 32'd0);
        pwm_duty_cycle = 8'h50;                           // mid-period: held off
        measure(1, 156, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("b3_high", 32'(hi), 32'd0);
        check("b3_ps_n", 32'(ps_n), 32'd0);
        measure(1, 256, 16'hFFFF, 16'h0000, hi, other, ps_n, ps_first, ps_last);
        check("b4_high", 32'(hi), 32'd80);
        check("b4_ps_n", 32'(ps_n), 32'd1);

        // ---- Enable override mid-period, duty 0x80 ----
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'h80;
        do_reset();
        repeat (10) @(negedge clk);                       // edge 10: high phase
        check("ovr_pre", 32'(out13), 32'hFFFF);
        set_en(16'hFFDF, 16'hFFFF);
        @(negedge clk);
        check("ovr_en_out_clear", 32'(out13), 32'hFFDF);
        repeat (1989) @(negedge clk);                     // edge 2000: low phase
        check("ovr_low_phase", 32'(out13), 32'h0000);
        set_en(16'hFFFF, 16'hFFDF);
        @(negedge clk);
        check("ovr_static_high", 32'(out13), 32'h0020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
